dm_port_arbiter: RTL

//  Two-master arbiter and sequencer for the single data-memory port.
//  M0 is the pipeline MEM stage; M1 is a secondary requester (debug/DMA bridge).
//  One access is granted per cycle; writes commit at the clock edge; read data is registered.

---
 rtl/dm_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-master arbiter and sequencer for the single data-memory port.
// M0 is the pipeline MEM stage and M1 is a secondary requester (debug/DMA bridge).
// One access is granted per cycle. Grants and dm_* outputs are combinational,
// writes commit at the clock edge, and read data is registered per master.
// Ties are round-robin. M1 may hold the port for bursts of at most LOCK_MAX grants.
// Optional build macro: DM_ARB_TRACE_EN prints one trace line per DM write.
module dm_port_arbiter #(
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_pc,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    state_t        state;
    logic          last;
    logic [CW-1:0] lock_cnt;

    logic          lock_hold;
    logic          tie_last;
    logic          sel_m1;
    logic          any_gnt;
    logic          win_we;
    logic [3:0]    win_be;
    logic [31:0]   win_addr;
    logic [31:0]   win_wdata;

    // Pick the winner: a live lock keeps M1, otherwise single requester or round-robin tie.
    always_comb begin
        lock_hold = 1'b0;
        tie_last  = last;
        sel_m1    = 1'b0;
        if (state == LOCK1 && m1_req && m1_lock && lock_cnt < LOCK_MAX_C) begin
            lock_hold = 1'b1;
        end
        // A saturated lock hands the exit cycle to M0 if it is waiting.
        if (state == LOCK1 && lock_cnt == LOCK_MAX_C) begin
            tie_last = 1'b1;
        end
        if (lock_hold) begin
            sel_m1 = 1'b1;
        end else if (m0_req && m1_req) begin
            sel_m1 = ~tie_last;
        end else begin
            sel_m1 = m1_req;
        end
    end

    assign any_gnt = ~reset & (m0_req | m1_req);
    assign m0_gnt  = any_gnt & ~sel_m1;
    assign m1_gnt  = any_gnt & sel_m1;

    // Route the winning master onto the memory port; everything reads as zero when idle.
    always_comb begin
        win_we    = sel_m1 ? m1_we    : m0_we;
        win_be    = sel_m1 ? m1_be    : m0_be;
        win_addr  = sel_m1 ? m1_addr  : m0_addr;
        win_wdata = sel_m1 ? m1_wdata : m0_wdata;
        dm_we     = 1'b0;
        dm_be     = 4'b0000;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        if (any_gnt) begin
            dm_we    = win_we & (win_be != 4'b0000);
            dm_be    = win_we ? win_be : 4'b0000;
            dm_addr  = {win_addr[31:2], 2'b00};
            dm_wdata = win_wdata;
        end
    end

    // Arbitration state: remember the last winner and track the M1 lock burst length.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            if (any_gnt) begin
                last <= sel_m1;
            end
            if (lock_hold) begin
                lock_cnt <= lock_cnt + CW'(1);
            end else if (state == LOCK1) begin
                state    <= ARB;
                lock_cnt <= '0;
            end else if (m1_gnt && m1_lock) begin
                state    <= LOCK1;
                lock_cnt <= CW'(1);
            end
        end
    end

    // Capture read data for whichever master was granted a read; rvalid pulses for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 32'h0;
            m1_rdata  <= 32'h0;
        end else begin
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= dm_rdata;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= dm_rdata;
            end
        end
    end

`ifdef DM_ARB_TRACE_EN
    logic [31:0] trace_pc;
    logic        unused_bits;

    assign trace_pc    = m1_gnt ? 32'hFFFF_FFFF : m0_pc;
    assign unused_bits = ^win_addr[1:0];

    // Log every committed DM write with the originating PC (all ones for M1).
    always @(posedge clk) begin
        if (dm_we) begin
            $display("%d@%h: *%h <= %h", $time, trace_pc, dm_addr, dm_wdata);
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{m0_pc, win_addr[1:0]};
`endif

endmodule
